// File: rtl/estimador_sched_pkg.sv
// Shared types and constants for the estimador operand scheduler.
package estimador_sched_pkg;

    // Number of requesters the scheduler is built for.
    localparam int NUM_REQ = 3;

    // Arbitration mode FSM.
    typedef enum logic {
        S_RR  = 1'b0,
        S_SEQ = 1'b1
    } state_t;

    // Requester index; value 3 is never produced.
    typedef logic [1:0] sel_t;

    // Successor of a requester index, modulo NUM_REQ.
    function automatic sel_t next_idx(input sel_t idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/estimador_rr_pick.sv
// Round-robin search: first valid requester strictly after last_grant, mod 3.
module estimador_rr_pick
    import estimador_sched_pkg::*;
(
    input  logic [1:0] last_grant,
    input  logic [2:0] valid,
    output logic [1:0] idx,
    output logic       found
);

    sel_t cand;

    // Walk the three candidates in priority order, keeping the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path would infer a latch.
        idx   = '0;
        found = 1'b0;
        cand  = last_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = next_idx(cand);
            if (!found && valid[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/estimador_operand_sched.sv
// Three-way operand scheduler with round-robin or strict 0->1->2 sequencing
// and a one-deep registered output stage.
// Optional macro ESTIMADOR_SCHED_STATS_EN adds saturating per-requester
// grant counters (grant_cnt0..2).
module estimador_operand_sched
    import estimador_sched_pkg::*;
#(
    parameter int DATA_W = 21,
    parameter int N_REQ  = 3
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic              seq_mode,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              busy
`ifdef ESTIMADOR_SCHED_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       grant_cnt2
`endif
);

    state_t            state_q, state_d;
    sel_t              last_grant_q;
    sel_t              exp_idx_q, exp_idx_d;
    sel_t              exp_eff;
    sel_t              rr_idx;
    logic              rr_found;
    sel_t              grant_idx;
    logic              grant_found;
    logic              load_en;
    logic              xfer;
    logic [DATA_W-1:0] grant_data;

    // The output stage can take a new operand when empty or draining now.
    assign load_en = !out_valid || out_ready;

    // Until the FSM has registered S_SEQ, sequencing starts from index 0.
    assign exp_eff = (state_q == S_SEQ) ? exp_idx_q : 2'd0;

    estimador_rr_pick u_rr_pick (
        .last_grant (last_grant_q),
        .valid      (req_valid),
        .idx        (rr_idx),
        .found      (rr_found)
    );

    // Mode FSM next state and grant selection; seq_mode takes effect at once.
    always_comb begin
        state_d     = state_q;
        exp_idx_d   = exp_idx_q;
        grant_idx   = rr_idx;
        grant_found = rr_found;
        case (state_q)
            S_RR: begin
                if (seq_mode) begin
                    state_d = S_SEQ;
                end
                exp_idx_d = 2'd0;
            end
            S_SEQ: begin
                if (!seq_mode) begin
                    state_d   = S_RR;
                    exp_idx_d = 2'd0;
                end
            end
            default: state_d = S_RR;
        endcase
        if (seq_mode) begin
            grant_idx   = exp_eff;
            grant_found = req_valid[exp_eff];
            exp_idx_d   = (grant_found && load_en) ? next_idx(exp_eff) : exp_eff;
        end
    end

    // One-hot ready for the granted requester, held low through reset.
    always_comb begin
        req_ready = '0;
        if (!ap_rst && load_en && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(req_valid & req_ready);

    // Operand mux for the granted requester.
    always_comb begin
        case (grant_idx)
            2'd0:    grant_data = req_data0;
            2'd1:    grant_data = req_data1;
            2'd2:    grant_data = req_data2;
            default: grant_data = '0;
        endcase
    end

    // FSM state and sequencing pointer.
    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (ap_rst) begin
            state_q   <= S_RR;
            exp_idx_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            exp_idx_q <= exp_idx_d;
        end
    end

    // Output stage, round-robin history and frame pulse.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sel      <= 2'd0;
            frame_done   <= 1'b0;
            last_grant_q <= 2'd2;
        end else begin
            if (xfer) begin
                out_data     <= grant_data;
                out_sel      <= grant_idx;
                out_valid    <= 1'b1;
                last_grant_q <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            frame_done <= xfer && seq_mode && (grant_idx == 2'd2);
        end
    end

    assign busy = out_valid || (|req_valid);

`ifdef ESTIMADOR_SCHED_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    // Per-requester transfer counters, saturating at all-ones.
    always_ff @(posedge ap_clk) begin
        // NOTE: this small counter array is reset explicitly; a wide storage
        // array would normally be left unreset and qualified by a valid bit.
        if (ap_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && grant_cnt[i] != 16'hFFFF) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt0 = grant_cnt[0];
    assign grant_cnt1 = grant_cnt[1];
    assign grant_cnt2 = grant_cnt[2];
`endif

endmodule

// File: tb/tb_estimador_operand_sched.sv
// Self-checking bench for estimador_operand_sched using a reference model
// and an output scoreboard.
module tb_estimador_operand_sched;

    localparam int DATA_W = 21;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [DATA_W-1:0] req_data0, req_data1, req_data2;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic              seq_mode;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;
    logic              busy;
`ifdef ESTIMADOR_SCHED_STATS_EN
    logic [15:0]       grant_cnt0, grant_cnt1, grant_cnt2;
`endif

    always #5 ap_clk = ~ap_clk;

    estimador_operand_sched #(.DATA_W(DATA_W), .N_REQ(3)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .seq_mode   (seq_mode),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef ESTIMADOR_SCHED_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .grant_cnt2 (grant_cnt2)
`endif
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        sel;
    } exp_t;

    int   tests  = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model state.
    bit   m_vld;
    bit   m_fd;
    int   m_last;
    int   m_exp;

    function automatic logic [DATA_W-1:0] data_of(input int i);
        case (i)
            0:       return req_data0;
            1:       return req_data1;
            default: return req_data2;
        endcase
    endfunction

    // One clock cycle: check combinational outputs, advance the model,
    // clock the DUT and check the registered outputs.
    task automatic step();
        bit         load;
        bit         found;
        int         idx;
        logic [2:0] exp_ready;
        exp_t       e;
        #1;
        load  = !m_vld || out_ready;
        found = 1'b0;
        idx   = 0;
        if (seq_mode) begin
            idx   = m_exp;
            found = req_valid[idx];
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    idx   = c;
                end
            end
        end
        exp_ready = (load && found) ? (3'b001 << idx) : 3'b000;

        tests++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        tests++;
        if (busy !== (m_vld || (|req_valid))) begin
            errors++;
            $display("FAIL busy: got %b expected %b", busy, m_vld || (|req_valid));
        end
        if (m_vld) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: empty while output expected valid");
            end else begin
                e = sb[0];
                if (out_data !== e.data || out_sel !== e.sel) begin
                    errors++;
                    $display("FAIL out_data/out_sel: got %h/%0d expected %h/%0d",
                             out_data, out_sel, e.data, e.sel);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end

        if (exp_ready != 3'b000) begin
            sb.push_back(exp_t'{data: data_of(idx), sel: 2'(idx)});
            m_last = idx;
            m_vld  = 1'b1;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
        m_fd = (exp_ready != 3'b000) && seq_mode && (idx == 2);
        if (seq_mode) begin
            if (exp_ready != 3'b000) m_exp = (m_exp == 2) ? 0 : m_exp + 1;
        end else begin
            m_exp = 0;
        end

        @(posedge ap_clk);
        @(negedge ap_clk);
        tests++;
        if (out_valid !== m_vld) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_vld);
        end
        tests++;
        if (frame_done !== m_fd) begin
            errors++;
            $display("FAIL frame_done: got %b expected %b", frame_done, m_fd);
        end
    endtask

    // Apply one reset cycle with whatever inputs are present and check it.
    task automatic do_reset();
        ap_rst = 1'b1;
        #1;
        tests++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 000", req_ready);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d fd=%b expected 0/0/0/0",
                     out_valid, out_data, out_sel, frame_done);
        end
        m_vld  = 1'b0;
        m_fd   = 1'b0;
        m_last = 2;
        m_exp  = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        req_valid = 3'b000;
        out_ready = 1'b1;
        seq_mode  = 1'b0;
        req_data0 = 21'h00011;
        req_data1 = 21'h00022;
        req_data2 = 21'h00033;
        @(negedge ap_clk);
        do_reset();
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd0;
        do_reset();
        req_data0 = 21'h0A000;
        req_data1 = 21'h0B111;
        req_data2 = 21'h0C222;
        req_valid = 3'b111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got v=%b sel=%0d expected v=1 sel=%0d",
                         i, out_valid, out_sel, exp_sel[i]);
            end
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_backpressure();
        req_valid = 3'b001;
        req_data0 = 21'h1ABCD;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (out_data !== 21'h1ABCD || out_sel !== 2'd0 || req_ready !== 3'b000) begin
                errors++;
                $display("FAIL hold[%0d]: got d=%h s=%0d rdy=%b expected 1abcd/0/000",
                         i, out_data, out_sel, req_ready);
            end
        end
        req_valid = 3'b000;
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_seq_mode();
        int         fd_count;
        logic [1:0] exp_sel [3];
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2;
        fd_count  = 0;
        out_ready = 1'b1;
        seq_mode  = 1'b1;
        req_valid = 3'b110;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_wait[%0d]: got out_valid=%b expected 0", i, out_valid);
            end
        end
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            if (frame_done) fd_count++;
            tests++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[i]) begin
                errors++;
                $display("FAIL seq_order[%0d]: got v=%b sel=%0d expected v=1 sel=%0d",
                         i, out_valid, out_sel, exp_sel[i]);
            end
        end
        req_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            if (frame_done) fd_count++;
        end
        tests++;
        if (fd_count != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 1", fd_count);
        end
        seq_mode = 1'b0;
        step();
    endtask

    task automatic test_mode_change_hold();
        req_data0 = 21'h15A5A;
        req_valid = 3'b001;
        out_ready = 1'b0;
        seq_mode  = 1'b0;
        step();
        req_valid = 3'b111;
        seq_mode  = 1'b1;
        step();
        seq_mode  = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 21'h15A5A || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL mode_hold: got v=%b d=%h s=%0d expected 1/15a5a/0",
                     out_valid, out_data, out_sel);
        end
        req_valid = 3'b000;
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        req_data1 = 21'h0F0F0;
        req_valid = 3'b010;
        out_ready = 1'b0;
        step();
        step();
        do_reset();
        req_valid = 3'b111;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_grant: got v=%b sel=%0d expected 1/0", out_valid, out_sel);
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_idle();
        req_valid = 3'b000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        req_valid = 3'b100;
        step();
        tests++;
        if (out_sel !== 2'd2) begin
            errors++;
            $display("FAIL idle_then_grant: got sel=%0d expected 2", out_sel);
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_data0 = DATA_W'($urandom);
            req_data1 = DATA_W'($urandom);
            req_data2 = DATA_W'($urandom);
            req_valid = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) seq_mode = ~seq_mode;
            step();
        end
        seq_mode  = 1'b0;
        req_valid = 3'b000;
        out_ready = 1'b1;
        step();
        step();
    endtask

`ifdef ESTIMADOR_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        seq_mode  = 1'b0;
        out_ready = 1'b1;
        req_valid = 3'b010;
        repeat (70000) @(negedge ap_clk);
        req_valid = 3'b000;
        @(negedge ap_clk);
        tests++;
        if (grant_cnt1 !== 16'hFFFF || grant_cnt0 !== 16'h0000 || grant_cnt2 !== 16'h0000) begin
            errors++;
            $display("FAIL grant_cnt: got %h/%h/%h expected 0000/ffff/0000",
                     grant_cnt0, grant_cnt1, grant_cnt2);
        end
        do_reset();
        tests++;
        if (grant_cnt1 !== 16'h0000) begin
            errors++;
            $display("FAIL grant_cnt_reset: got %h expected 0000", grant_cnt1);
        end
    endtask
`endif

    initial begin
        ap_rst = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_seq_mode();
        test_mode_change_hold();
        test_reset_mid();
        test_idle();
        test_random();
`ifdef ESTIMADOR_SCHED_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/estimador_operand_sched.md
ESTIMADOR_OPERAND_SCHED -- requirements
Module: estimador_operand_sched

Interface
REQ-001 Parameter DATA_W, default 21, operand width in bits.
REQ-002 Parameter N_REQ, default 3, number of requesters; only 3 is supported.
REQ-003 ap_clk  in  1  single clock; all logic is rising-edge.
REQ-004 ap_rst  in  1  reset, synchronous and active-high.
REQ-005 req_data0, req_data1, req_data2  in  DATA_W each  requester operands.
REQ-006 req_valid  in  3  per-requester valid; bit i belongs to req_data<i>.
REQ-007 req_ready  out  3  per-requester ready, one-hot or zero.
REQ-008 seq_mode  in  1  0 = round-robin arbitration; 1 = strict 0->1->2 sequencing.
REQ-009 out_data  out  DATA_W  registered granted operand.
REQ-010 out_sel  out  2  index of the requester that sourced out_data; encoding is mux-compatible; 3 is never driven.
REQ-011 out_valid  out  1  out_data/out_sel valid.
REQ-012 out_ready  in  1  downstream accepts the output.
REQ-013 frame_done  out  1  one-cycle pulse when requester 2 is accepted in sequence mode.
REQ-014 busy  out  1  out_valid or any req_valid set.

Function
REQ-015 Requester transfer occurs when req_valid[i] and req_ready[i] are both high in the same cycle; output transfer occurs when out_valid and out_ready are both high.
REQ-016 Load condition is !out_valid, or out_valid and out_ready; req_ready is zero when the load condition is false.
REQ-017 Round-robin mode: grant the first valid index after last_grant, modulo 3; req_ready is the one-hot of that index, combinational from registered state and req_valid.
REQ-018 Sequence mode: grant only index exp_idx (0, then 1, then 2, then back to 0); other requesters wait even when valid.
REQ-019 On each requester transfer, out_data/out_sel load on the next edge, out_valid=1, and last_grant updates to the granted index.
REQ-020 Latency is 1 cycle from requester transfer to out_valid; sustained throughput is 1 transfer per cycle when out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_sel hold stable.
REQ-022 Simultaneous drain and load in one cycle is legal and causes no bubble.
REQ-023 An output drain with no load clears out_valid on the next edge.
REQ-024 FSM states: S_RR and S_SEQ. seq_mode 0->1 enters S_SEQ with exp_idx=0; 1->0 returns to S_RR with last_grant unchanged.
REQ-025 A mode change never alters a held output.
REQ-026 frame_done asserts the cycle after the index-2 transfer in S_SEQ; exp_idx wraps 2->0.
REQ-027 No valid requesters means no grant and no state change.

Reset
REQ-028 ap_rst=1 forces out_valid=0, out_data=0, out_sel=0, frame_done=0, last_grant=2 (first RR grant goes to 0), exp_idx=0, state S_RR, and counters 0.
REQ-029 req_ready=0 for the whole reset cycle.
REQ-030 Reset mid-transfer discards the held output.

Configuration
REQ-031 With macro ESTIMADOR_SCHED_STATS_EN defined, add outputs grant_cnt0, grant_cnt1 and grant_cnt2 (16 bits each), counting requester transfers, saturating at 16'hFFFF, and cleared by reset.
REQ-032 Without ESTIMADOR_SCHED_STATS_EN, these ports and counters are absent, and all other behaviour is identical.

Structure
REQ-033 Shared package estimador_sched_pkg holds the state enum (S_RR, S_SEQ), the N_REQ constant, and the sel index typedef (2 bits).
REQ-034 One sub-module, estimador_rr_pick, performs the combinational next-index search from last_grant and the 3-bit valid vector.

Verification
REQ-035 After reset: all req_valid=3'b111, out_ready=1, seq_mode=0 -> out_sel sequence 0,1,2,0 on consecutive cycles, with out_valid continuously high.
REQ-036 out_ready=0 for 4 cycles with req_valid=3'b001 and req_data0=21'h1ABCD -> out_data=21'h1ABCD held, out_sel=0, req_ready=0 until out_ready rises.
REQ-037 seq_mode=1, req_valid=3'b110 -> no grant; raising req_valid[0] -> grants 0,1,2, then frame_done pulses exactly once.
REQ-038 ap_rst pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and out_data=0; the next grant goes to index 0.
REQ-039 With ESTIMADOR_SCHED_STATS_EN, 70000 transfers from requester 1 -> grant_cnt1=16'hFFFF, grant_cnt0=0, grant_cnt2=0.
